// File: rtl/hour_counter24.sv
// BCD hour counter 00..23 advanced by upstream CAR rising edges and manual set requests.
// Latency: one clk from an input rising edge to updated HR10/HR1/PM/DAY_CAR.
// Backpressure: none; every event is absorbed in its own cycle, and coincident events step twice.
module hour_counter24 #(
    parameter logic CAR_INIT = 1'b1,
    parameter logic SET_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       car_in,
    input  logic       set_inc,
    input  logic       mode12,
    output logic [1:0] HR10,
    output logic [3:0] HR1,
    output logic       PM,
    output logic       DAY_CAR
);

    // Internal count and input history
    logic [1:0] t;
    logic [3:0] u;
    logic       car_q;
    logic       set_q;

    // Combinational next-state
    logic       car_ev;
    logic       set_ev;
    logic [6:0] step1;
    logic [6:0] step2;
    logic [1:0] t_nxt;
    logic [3:0] u_nxt;
    logic       wrap;

    // Display decode of the next-state count
    logic [4:0] h;
    logic [4:0] h_minus12;
    logic [3:0] d;
    logic [1:0] disp_hr10;
    logic [3:0] disp_hr1;
    logic       disp_pm;

    // One BCD step; result is {wrapped_23_to_00, t, u}. Illegal codes recover to 00
    // without flagging a wrap so a corrupted count never fakes a day carry.
    function automatic logic [6:0] bcd_step(input logic [1:0] ti, input logic [3:0] ui);
        logic [6:0] r;
        if (ti == 2'd2 && ui == 4'd3) begin
            r = {1'b1, 2'd0, 4'd0};
        end else if (ti == 2'd3 || (ti == 2'd2 && ui > 4'd3) || ui > 4'd9) begin
            r = {1'b0, 2'd0, 4'd0};
        end else if (ui == 4'd9) begin
            r = {1'b0, ti + 2'd1, 4'd0};
        end else begin
            r = {1'b0, ti, ui + 4'd1};
        end
        return r;
    endfunction

    // Edge detect both requests and compute the single or double step
    always_comb begin
        car_ev = car_in & ~car_q;
        set_ev = set_inc & ~set_q;
        step1  = bcd_step(t, u);
        step2  = bcd_step(step1[5:4], step1[3:0]);
        t_nxt  = t;
        u_nxt  = u;
        wrap   = 1'b0;
        if (car_ev && set_ev) begin
            t_nxt = step2[5:4];
            u_nxt = step2[3:0];
            wrap  = step1[6] | step2[6];
        end else if (car_ev || set_ev) begin
            t_nxt = step1[5:4];
            u_nxt = step1[3:0];
            wrap  = step1[6];
        end
    end

    // Map the next-state hour to 24h or 12h display digits and the PM flag
    always_comb begin
        h         = ({3'd0, t_nxt} * 5'd10) + {1'b0, u_nxt};
        h_minus12 = h - 5'd12;
        disp_pm   = (h >= 5'd12);
        if (h == 5'd0) begin
            d = 4'd12;
        end else if (h <= 5'd12) begin
            d = h[3:0];
        end else begin
            d = h_minus12[3:0];
        end
        if (mode12) begin
            disp_hr10 = (d >= 4'd10) ? 2'd1 : 2'd0;
            disp_hr1  = (d >= 4'd10) ? (d - 4'd10) : d;
        end else begin
            disp_hr10 = t_nxt;
            disp_hr1  = u_nxt;
        end
    end

    // Count and edge-history registers; history reload to CAR_INIT hides a CAR already high at release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t     <= 2'd0;
            u     <= 4'd0;
            car_q <= CAR_INIT;
            set_q <= SET_INIT;
        end else begin
            t     <= t_nxt;
            u     <= u_nxt;
            car_q <= car_in;
            set_q <= set_inc;
        end
    end

    // Registered display outputs and day-carry pulse (only a CAR-driven wrap counts)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            HR10    <= 2'd0;
            HR1     <= 4'd0;
            PM      <= 1'b0;
            DAY_CAR <= 1'b0;
        end else begin
            HR10    <= disp_hr10;
            HR1     <= disp_hr1;
            PM      <= disp_pm;
            DAY_CAR <= car_ev & wrap;
        end
    end

endmodule

// File: tb/tb_hour_counter24.sv
// Directed bench for hour_counter24: stimulus pushes expected outputs into a scoreboard queue,
// a monitor pops and compares on the falling edge of the cycle each entry is due.
// Entries are due one clk after the inputs that cause them.
module tb_hour_counter24;

    logic       clk = 1'b0;
    logic       rst;
    logic       car_in;
    logic       set_inc;
    logic       mode12;
    logic [1:0] HR10;
    logic [3:0] HR1;
    logic       PM;
    logic       DAY_CAR;

    hour_counter24 #(.CAR_INIT(1'b1), .SET_INIT(1'b0)) dut (
        .clk     (clk),
        .rst     (rst),
        .car_in  (car_in),
        .set_inc (set_inc),
        .mode12  (mode12),
        .HR10    (HR10),
        .HR1     (HR1),
        .PM      (PM),
        .DAY_CAR (DAY_CAR)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [1:0] hr10;
        logic [3:0] hr1;
        logic       pm;
        logic       dc;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string nm, input int due, input logic [1:0] hr10,
                        input logic [3:0] hr1, input logic pm, input logic dc);
        exp_t e;
        e.due  = due;
        e.hr10 = hr10;
        e.hr1  = hr1;
        e.pm   = pm;
        e.dc   = dc;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Expect raw display values after the coming clock edge
    task automatic expect_next(input string nm, input logic [1:0] hr10, input logic [3:0] hr1,
                               input logic pm, input logic dc);
        push(nm, cyc + 1, hr10, hr1, pm, dc);
        tick();
    endtask

    // Expect a 24h-mode hour after the coming clock edge
    task automatic expect_hour(input string nm, input int hr, input logic dc);
        logic [1:0] t10;
        logic [3:0] t1;
        t10 = 2'(hr / 10);
        t1  = 4'(hr % 10);
        expect_next(nm, t10, t1, hr >= 12, dc);
    endtask

    task automatic adv_set(input int n);
        repeat (n) begin
            set_inc = 1'b1;
            tick();
            set_inc = 1'b0;
            tick();
        end
    endtask

    // Monitor: compare every entry due in the current cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.due != cyc || HR10 !== e.hr10 || HR1 !== e.hr1 || PM !== e.pm || DAY_CAR !== e.dc) begin
                    errors++;
                    $display("FAIL %s (cycle %0d due %0d): got HR10=%0d HR1=%0d PM=%0d DAY_CAR=%0d, want HR10=%0d HR1=%0d PM=%0d DAY_CAR=%0d",
                             e.name, cyc, e.due, HR10, HR1, PM, DAY_CAR, e.hr10, e.hr1, e.pm, e.dc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1);
    end

    // 12h table: set steps to apply, then expected display and PM
    int         steps12 [6] = '{0, 1, 10, 1, 1, 10};
    logic [1:0] exp10   [6] = '{2'd1, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1};
    logic [3:0] exp1    [6] = '{4'd2, 4'd1, 4'd1, 4'd2, 4'd1, 4'd1};
    logic       exppm   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        rst     = 1'b0;
        car_in  = 1'b1;
        set_inc = 1'b0;
        mode12  = 1'b0;
        tick();
        push("reset_state", cyc, 2'd0, 4'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;

        // CAR high out of reset must not count
        repeat (20) expect_hour("car_high_after_reset", 0, 1'b0);

        // 24 CAR pulses: full day, one DAY_CAR on the wrap
        for (int i = 1; i <= 24; i++) begin
            car_in = 1'b0;
            expect_hour("car_low_hold", (i - 1) % 24, 1'b0);
            car_in = 1'b1;
            expect_hour("car_rise", i % 24, i == 24);
        end
        expect_hour("day_car_one_cycle", 0, 1'b0);

        // 12h display through 00,01,11,12,13,23
        mode12 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            adv_set(steps12[k]);
            expect_next("mode12_table", exp10[k], exp1[k], exppm[k], 1'b0);
        end
        mode12 = 1'b0;
        expect_hour("mode_back_24h", 23, 1'b0);

        // Set-only wrap, then a long set level counts once
        set_inc = 1'b1;
        expect_hour("set_wrap_no_daycar", 0, 1'b0);
        set_inc = 1'b0;
        expect_hour("set_release", 0, 1'b0);
        set_inc = 1'b1;
        expect_hour("set_hold_rise", 1, 1'b0);
        repeat (49) expect_hour("set_hold_level", 1, 1'b0);
        set_inc = 1'b0;
        expect_hour("set_hold_release", 1, 1'b0);

        // Coincident CAR and set edges step twice
        adv_set(21);
        expect_hour("at_22", 22, 1'b0);
        car_in = 1'b0;
        expect_hour("car_low_22", 22, 1'b0);
        car_in  = 1'b1;
        set_inc = 1'b1;
        expect_hour("both_from_22", 0, 1'b1);
        car_in  = 1'b0;
        set_inc = 1'b0;
        expect_hour("both_22_pulse_end", 0, 1'b0);
        adv_set(23);
        expect_hour("at_23", 23, 1'b0);
        car_in  = 1'b1;
        set_inc = 1'b1;
        expect_hour("both_from_23", 1, 1'b1);
        car_in  = 1'b0;
        set_inc = 1'b0;
        expect_hour("both_23_pulse_end", 1, 1'b0);
        adv_set(8);
        expect_hour("at_09", 9, 1'b0);
        car_in  = 1'b1;
        set_inc = 1'b1;
        expect_hour("both_from_09", 11, 1'b0);
        car_in  = 1'b0;
        set_inc = 1'b0;
        expect_hour("hold_11", 11, 1'b0);
        adv_set(8);
        expect_hour("at_19", 19, 1'b0);
        car_in  = 1'b1;
        set_inc = 1'b1;
        expect_hour("both_from_19", 21, 1'b0);
        car_in  = 1'b0;
        set_inc = 1'b0;
        expect_hour("hold_21", 21, 1'b0);

        // Async reset mid-cycle with CAR high
        adv_set(17);
        expect_hour("at_14", 14, 1'b0);
        car_in = 1'b1;
        expect_hour("car_to_15", 15, 1'b0);
        tick();
        #2;
        rst = 1'b0;
        push("reset_async_immediate", cyc, 2'd0, 4'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        repeat (5) expect_hour("post_reset_car_high", 0, 1'b0);
        car_in = 1'b0;
        expect_hour("post_reset_car_low", 0, 1'b0);
        car_in = 1'b1;
        expect_hour("post_reset_car_rise", 1, 1'b0);

        tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
